// File: rtl/adder_if.sv
// Bundle of signals for the registered adder.
// The dut_mp modport is the adder's view; clk is an interface port so the
// environment that owns the clock also owns the interface instance.
interface adder_if #(
    parameter int WIDTH     = 4,
    parameter int OUT_WIDTH = 7
) (
    input logic clk
);
    logic                 reset;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 valid;
    logic [OUT_WIDTH-1:0] c;
    logic                 out_valid;
    logic                 carry;

    modport dut_mp (
        input  clk,
        input  reset,
        input  a,
        input  b,
        input  valid,
        output c,
        output out_valid,
        output carry
    );
endinterface

// File: rtl/adder.sv
// Registered unsigned adder: one sum per clock, one cycle of latency.
//
// Handshake: valid qualifies a and b for the single cycle it is high; there
// is no ready, the adder accepts every valid beat. out_valid pulses for one
// cycle when c/carry carry a freshly computed sum; otherwise c and carry hold
// the last accepted result. a and b are don't-care while valid is low.
module adder #(
    parameter int WIDTH     = 4,
    parameter int OUT_WIDTH = 7
) (
    adder_if.dut_mp bus
);

    // The sum needs WIDTH+1 bits, and the operand width is bounded to 1..16.
    if (WIDTH < 1 || WIDTH > 16 || OUT_WIDTH < WIDTH + 1) begin : g_bad_params
        $error("adder: need 1 <= WIDTH <= 16 and OUT_WIDTH >= WIDTH+1");
    end

    logic [WIDTH:0]       sum;
    logic [OUT_WIDTH-1:0] sum_ext;

    // Full-width sum, then zero-extend so bits above WIDTH are always 0.
    always_comb begin
        sum              = {1'b0, bus.a} + {1'b0, bus.b};
        sum_ext          = '0;
        sum_ext[WIDTH:0] = sum;
    end

    // Result registers: reset clears at once; valid loads; otherwise hold.
    always_ff @(posedge bus.clk or posedge bus.reset) begin
        if (bus.reset) begin
            bus.c         <= '0;
            bus.carry     <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (bus.valid) begin
            bus.c         <= sum_ext;
            bus.carry     <= sum[WIDTH];
            bus.out_valid <= 1'b1;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed cases followed by random traffic,
// with a scoreboard queue of expected {carry, c} results.
module tb_adder;
    localparam int WIDTH     = 4;
    localparam int OUT_WIDTH = 7;

    logic clk;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_on   = 1'b0;

    logic [OUT_WIDTH:0]   exp_q[$];
    logic [OUT_WIDTH-1:0] model_c;
    logic                 model_carry;

    adder_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus (.clk(clk));

    adder #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (.bus(bus));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison helper used for every check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {carry, c} from the reference sum
    function automatic logic [OUT_WIDTH:0] ref_sum(input int x, input int y);
        int s;
        logic [OUT_WIDTH:0] r;
        s = x + y;
        r = '0;
        r[OUT_WIDTH]     = ((s >> WIDTH) & 1) != 0;
        r[OUT_WIDTH-1:0] = OUT_WIDTH'(s);
        return r;
    endfunction

    // Driver: called just after a rising edge; applies inputs, then consumes
    // the next edge. Accepted beats push their expected result.
    task automatic step(input int x, input int y, input bit v);
        bus.a     = WIDTH'(x);
        bus.b     = WIDTH'(y);
        bus.valid = v;
        if (v && !bus.reset) exp_q.push_back(ref_sum(x, y));
        @(posedge clk);
        #1;
    endtask

    // Monitor: on every falling edge compare outputs with the scoreboard model
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.reset) begin
                check("rst_c", 32'(bus.c), 0);
                check("rst_carry", 32'(bus.carry), 0);
                check("rst_out_valid", 32'(bus.out_valid), 0);
                model_c     = '0;
                model_carry = 1'b0;
            end else if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 32'(bus.c), 32'hFFFF_FFFF);
                end else begin
                    logic [OUT_WIDTH:0] e;
                    e = exp_q.pop_front();
                    check("sum_c", 32'(bus.c), 32'(e[OUT_WIDTH-1:0]));
                    check("sum_carry", 32'(bus.carry), 32'(e[OUT_WIDTH]));
                    model_c     = e[OUT_WIDTH-1:0];
                    model_carry = e[OUT_WIDTH];
                end
            end else begin
                check("hold_c", 32'(bus.c), 32'(model_c));
                check("hold_carry", 32'(bus.carry), 32'(model_carry));
            end
        end
    end

    // Main stimulus
    initial begin
        bus.reset   = 1'b1;
        bus.a       = '0;
        bus.b       = '0;
        bus.valid   = 1'b0;
        model_c     = '0;
        model_carry = 1'b0;
        mon_on      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_c", 32'(bus.c), 0);
        check("reset_out_valid", 32'(bus.out_valid), 0);
        bus.reset = 1'b0;

        // Idle after release: everything stays 0, no spurious pulse
        repeat (3) step(0, 0, 0);
        check("idle_c", 32'(bus.c), 0);
        check("idle_out_valid", 32'(bus.out_valid), 0);

        // 3 + 5
        step(3, 5, 1);
        check("3p5_c", 32'(bus.c), 8);
        check("3p5_carry", 32'(bus.carry), 0);
        check("3p5_out_valid", 32'(bus.out_valid), 1);
        step(0, 0, 0);
        check("3p5_after_out_valid", 32'(bus.out_valid), 0);
        check("3p5_after_c", 32'(bus.c), 8);

        // Operands ignored while valid is low
        step(9, 9, 0);
        check("ignore_c", 32'(bus.c), 8);
        check("ignore_out_valid", 32'(bus.out_valid), 0);

        // Maximum operands
        step(15, 15, 1);
        check("max_c", 32'(bus.c), 30);
        check("max_carry", 32'(bus.carry), 1);
        check("max_upper_bits", 32'(bus.c[OUT_WIDTH-1:WIDTH+1]), 0);

        // Asynchronous reset between accept and edge: transaction discarded
        bus.a     = 4'd10;
        bus.b     = 4'd4;
        bus.valid = 1'b1;
        #2;
        bus.reset = 1'b1;
        #1;
        check("async_rst_c", 32'(bus.c), 0);
        check("async_rst_carry", 32'(bus.carry), 0);
        check("async_rst_out_valid", 32'(bus.out_valid), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_priority_c", 32'(bus.c), 0);
        check("rst_priority_out_valid", 32'(bus.out_valid), 0);
        bus.reset = 1'b0;
        step(0, 0, 0);
        check("post_rst_c", 32'(bus.c), 0);
        check("post_rst_out_valid", 32'(bus.out_valid), 0);

        // Back-to-back beats
        step(1, 2, 1);
        check("b2b0_c", 32'(bus.c), 3);
        check("b2b0_carry", 32'(bus.carry), 0);
        check("b2b0_out_valid", 32'(bus.out_valid), 1);
        step(7, 9, 1);
        check("b2b1_c", 32'(bus.c), 16);
        check("b2b1_carry", 32'(bus.carry), 1);
        check("b2b1_out_valid", 32'(bus.out_valid), 1);
        step(0, 0, 1);
        check("b2b2_c", 32'(bus.c), 0);
        check("b2b2_carry", 32'(bus.carry), 0);
        check("b2b2_out_valid", 32'(bus.out_valid), 1);

        // Random traffic; the monitor checks every cycle
        for (int i = 0; i < 1000; i++) begin
            step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 bit'($urandom_range(0, 1)));
        end
        repeat (2) step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; the module SHALL be correct for WIDTH 1..16.
REQ-002 Parameter: OUT_WIDTH, default 7, result width; the module SHALL require OUT_WIDTH >= WIDTH+1 and zero-extend the sum to it.
REQ-003 The module SHALL have a single port of interface type adder_if, connected through modport dut_mp; the signals below are that modport's directions as seen by adder.
REQ-004 clk  input  1  single clock; all sequential logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 a  input  WIDTH  first unsigned operand.
REQ-007 b  input  WIDTH  second unsigned operand.
REQ-008 valid  input  1  qualifies a and b for one cycle.
REQ-009 c  output  OUT_WIDTH  registered unsigned sum a+b, zero-extended.
REQ-010 out_valid  output  1  high for exactly one cycle when c holds a newly computed sum.
REQ-011 carry  output  1  registered carry-out, i.e. bit WIDTH of a+b.

Function
REQ-012 On a rising clk edge with valid=1, the module SHALL load c <= zero_extend(a+b) computed at WIDTH+1 bits, carry <= bit WIDTH of the sum, and out_valid <= 1.
REQ-013 On a rising clk edge with valid=0, the module SHALL hold c and carry and drive out_valid <= 0.
REQ-014 Latency SHALL be exactly one clock: a result sampled at edge N is visible after edge N and stays stable until the next accepted valid.
REQ-015 Back-to-back valid cycles SHALL each produce a result; throughput is one sum per clock with no stalls or back-pressure.
REQ-016 Arithmetic SHALL be unsigned, with no wrap: the maximum 15+15 (WIDTH=4) gives c=30 and carry=1.
REQ-017 Bits of c above WIDTH SHALL always be 0.
REQ-018 a and b SHALL be ignored whenever valid=0, including X or changing values.
REQ-019 The module SHALL have no combinational path from inputs to outputs.

Reset
REQ-020 While reset=1, c, carry and out_valid SHALL be 0, taking effect immediately with no clock edge required.
REQ-021 reset SHALL take priority over valid on any edge where both are high; that transaction is discarded.
REQ-022 Reset asserted mid-stream SHALL clear all outputs at once; after release, the first rising edge with valid=1 produces a normal result one cycle later.
REQ-023 Release of reset SHALL not generate a spurious out_valid pulse.

Verification
REQ-024 Assert reset, then release; drive no valid -> c=0, carry=0, out_valid=0 throughout.
REQ-025 Drive a=3, b=5, valid=1 for one cycle -> the next cycle shows c=8, carry=0, out_valid=1; the following cycle shows out_valid=0 and c still 8.
REQ-026 Drive a=15, b=15, valid=1 -> c=30 (7'b0011110), carry=1, upper bits zero.
REQ-027 Drive back-to-back valid with (1,2), (7,9), (0,0) -> over three consecutive cycles c=3, 16, 0 with carry=0, 1, 0 and out_valid high on all three.
REQ-028 Drive a=9, b=9, valid=0 after a prior result of 8 -> c stays 8 and out_valid stays 0.
REQ-029 Drive a=10, b=4, valid=1 and assert reset asynchronously before the next edge -> c=0 and out_valid=0 immediately, and no result of 14 ever appears.
REQ-030 Run 1000 random (a, b, valid) cycles -> every out_valid pulse matches a reference sum of the inputs accepted one cycle earlier.
